// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch path: state encoding, HALT code,
// default widths and the constant branch-target table.
package isa_pkg;

    localparam int PCW_DEF  = 10;
    localparam int IW_DEF   = 9;
    localparam int LUTW_DEF = 3;

    localparam logic [IW_DEF-1:0] HALT = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Eight fixed branch targets, stored wide and narrowed by the consumer.
    function automatic logic [15:0] lut_entry(input logic [2:0] idx);
        logic [15:0] t;
        case (idx)
            3'd0:    t = 16'd3;
            3'd1:    t = 16'd20;
            3'd2:    t = 16'd40;
            3'd3:    t = 16'd100;
            3'd4:    t = 16'd200;
            3'd5:    t = 16'd512;
            3'd6:    t = 16'd1000;
            default: t = 16'd1023;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/branch_lut.sv
// Combinational branch-target lookup; indices beyond the eight entries alias.
module branch_lut
    import isa_pkg::*;
#(
    parameter int PCW  = PCW_DEF,
    parameter int LUTW = LUTW_DEF
) (
    input  logic [LUTW-1:0] LutIdx,
    output logic [PCW-1:0]  Target
);

    assign Target = PCW'(lut_entry(3'(LutIdx)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: walks the ROM from address 0 until it fetches
// HALT, honouring stalls and taken branches, and counts the RUN cycles.
module fetch_unit
    import isa_pkg::*;
#(
    parameter int PCW  = PCW_DEF,
    parameter int IW   = IW_DEF,
    parameter int LUTW = LUTW_DEF
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Branch,
    input  logic            Taken,
    input  logic [LUTW-1:0] LutIdx,
    input  logic            Stall,
    input  logic [IW-1:0]   InstrIn,
    output logic [PCW-1:0]  ProgCtr,
    output logic [IW-1:0]   Instr,
    output logic            InstrValid,
    output logic            Done,
    output logic [15:0]     CycleCount
);

    state_e          state_q, state_d;
    logic [PCW-1:0]  pc_q, pc_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [PCW-1:0]  br_target;
    logic            is_halt;

    branch_lut #(.PCW(PCW), .LUTW(LUTW)) u_lut (
        .LutIdx (LutIdx),
        .Target (br_target)
    );

    // HALT is the all-ones word at whatever width IW is configured to.
    assign is_halt = &InstrIn;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RUN: begin
                cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                if (is_halt)
                    state_d = S_DONE;
                else if (Stall)
                    pc_d = pc_q;
                else if (Branch && Taken)
                    pc_d = br_target;
                else
                    pc_d = pc_q + PCW'(1);
            end
            default: begin
                if (Start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ProgCtr    = pc_q;
    assign CycleCount = cnt_q;
    assign InstrValid = (state_q == S_RUN);
    assign Done       = (state_q == S_DONE);
    assign Instr      = InstrValid ? InstrIn : '0;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PCW, default 10, program counter and instruction-address width.
REQ-002 Parameter IW, default 9, instruction width.
REQ-003 Parameter LUTW, default 3, branch-target LUT index width.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Start  input  1  launches a program run; sampled only in IDLE or DONE.
REQ-007 Branch  input  1  branch instruction in decode; driven by the control decoder.
REQ-008 Taken  input  1  branch condition true (BNE: operands unequal).
REQ-009 LutIdx  input  LUTW  branch-target LUT index from the instruction field.
REQ-010 Stall  input  1  freezes the program counter for one cycle.
REQ-011 InstrIn  input  IW  instruction ROM read data for address ProgCtr, combinational.
REQ-012 ProgCtr  output  PCW  registered instruction-ROM address.
REQ-013 Instr  output  IW  instruction to decoder; equals InstrIn when InstrValid, else all zeros.
REQ-014 InstrValid  output  1  high only in RUN.
REQ-015 Done  output  1  high only in DONE.
REQ-016 CycleCount  output  16  number of RUN cycles in the current or last run.

Function
REQ-017 The unit SHALL implement states IDLE, RUN and DONE.
REQ-018 IDLE, Start=1: next state RUN, ProgCtr<=0, CycleCount<=0.
REQ-019 DONE, Start=1: same as IDLE with Start=1; otherwise DONE holds and ProgCtr/CycleCount keep their values.
REQ-020 Start while RUN SHALL be ignored.
REQ-021 RUN, InstrIn equals the HALT code (all ones): next state DONE, ProgCtr unchanged; HALT overrides Stall and Branch.
REQ-022 RUN, no HALT, Stall=1: ProgCtr unchanged, state RUN.
REQ-023 RUN, no HALT, Stall=0, Branch=1 and Taken=1: ProgCtr<=LUT[LutIdx].
REQ-024 RUN, no HALT, Stall=0, otherwise: ProgCtr<=ProgCtr+1 modulo 2^PCW; all-ones wraps to 0 with no flag.
REQ-025 Branch=1 with Taken=0 SHALL behave as sequential increment.
REQ-026 Branch, Taken and LutIdx SHALL be ignored outside RUN.
REQ-027 CycleCount SHALL increment by 1 on every RUN cycle, including stalled and HALT cycles, and saturate at 16'hFFFF.
REQ-028 Control-to-PC latency is one cycle: a branch decided in cycle n drives ProgCtr at cycle n+1, with no delay slot.
REQ-029 Done SHALL assert in the cycle after the HALT fetch and stay high until Start or Reset.

Reset
REQ-030 Reset=1 at a clock edge SHALL force IDLE, ProgCtr=0, CycleCount=0, InstrValid=0, Done=0 and Instr=0.
REQ-031 Reset SHALL override Start, Stall and Branch in the same cycle.
REQ-032 Reset mid-RUN SHALL abort the run with no Done pulse.

Structure
REQ-033 Shared package isa_pkg SHALL hold the state enum, HALT code, PCW/IW/LUTW defaults and the 8-entry constant branch-target table.
REQ-034 The branch target table SHALL be a separate combinational sub-module branch_lut, indexed by LutIdx and returning PCW bits.
REQ-035 The state register, ProgCtr and CycleCount SHALL live in fetch_unit.

Verification
REQ-036 Reset held 2 cycles, then Start pulse with ROM of incrementing non-HALT words -> ProgCtr 0,1,2,3..., InstrValid=1, Done=0.
REQ-037 At ProgCtr=5, Branch=1, Taken=1, LutIdx=2, LUT[2]=40 -> next ProgCtr=40; same stimulus with Taken=0 -> ProgCtr=6.
REQ-038 Stall=1 for 3 cycles at ProgCtr=7 -> ProgCtr stays 7 for 3 cycles, then 8; CycleCount advances by 4.
REQ-039 HALT at address 12 with Stall=1 and Branch=1 -> Done=1 next cycle, ProgCtr=12, InstrValid=0; Start -> ProgCtr=0, RUN.
REQ-040 ROM with no HALT run for 1024 cycles -> ProgCtr wraps from 1023 to 0.
REQ-041 Force CycleCount to saturate -> holds at 16'hFFFF.
REQ-042 Reset asserted at ProgCtr=30 in RUN -> next cycle IDLE, all outputs zero.
